// File: rtl/iir_pkg.sv
// ---------------------------------------------------------------------------
// iir_pkg : constants, sample type and saturation helper shared by the IIR
//           filter chain.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package iir_pkg;

  localparam int DATA_W    = 32;
  localparam int FRAC_BITS = 8;

  typedef logic signed [DATA_W-1:0] sample_t;

  // Clamp a wide signed value into the range of an out_w-bit signed word.
  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] value,
                                                    input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi)
      return hi;
    else if (value < lo)
      return lo;
    else
      return value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iir_sample_fifo.sv
// ---------------------------------------------------------------------------
// iir_sample_fifo : synchronous FIFO; head word reads as zero while empty.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module iir_sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_pop;
  logic             w_push;

  // Extra pointer bit distinguishes full from empty.
  assign level  = r_wr_ptr - r_rd_ptr;
  assign empty  = (level == '0);
  assign full   = (level == (AW+1)'(DEPTH));
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign dout   = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/iir_out_decimator.sv
// ---------------------------------------------------------------------------
// iir_out_decimator : accumulate-and-dump averager behind IIR_filter, with
//                     saturation to a narrow word and an output FIFO.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module iir_out_decimator #(
  parameter int DATA_W     = iir_pkg::DATA_W,
  parameter int FRAC_BITS  = iir_pkg::FRAC_BITS,
  parameter int DECIM_LOG2 = 2,
  parameter int OUT_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [DATA_W-1:0]      inData,
  input  logic                          in_en,
  output logic signed [OUT_W-1:0]       outData,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          sat_flag,
  output logic                          drop_flag,
  input  logic                          clr_flags
);

  import iir_pkg::*;

  localparam int ACC_W = DATA_W + DECIM_LOG2;
  localparam int CNT_W = DECIM_LOG2 + 1;
  localparam logic [CNT_W-1:0] c_last_idx = CNT_W'((1 << DECIM_LOG2) - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (FRAC_BITS >= OUT_W || ACC_W > 64 || OUT_W > 64) begin : g_bad_width
    $error("unsupported width parameters");
  end

  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_avg;
  logic signed [63:0]      w_avg_wide;
  logic signed [63:0]      w_sat_wide;
  logic signed [OUT_W-1:0] w_narrow;
  logic                    w_clamp;
  logic                    w_dump;
  logic                    w_pop;
  logic                    w_drop;
  logic                    w_fifo_empty;
  logic                    w_fifo_full;

  assign w_sum      = r_acc + ACC_W'(inData);
  assign w_avg      = w_sum >>> DECIM_LOG2;
  assign w_avg_wide = 64'(w_avg);
  assign w_sat_wide = sat_narrow(w_avg_wide, OUT_W);
  assign w_clamp    = (w_sat_wide != w_avg_wide);
  assign w_narrow   = w_sat_wide[OUT_W-1:0];

  assign w_dump    = in_en && (r_cnt == c_last_idx);
  assign w_pop     = out_valid && out_ready;
  // A full FIFO still accepts the result when the consumer frees a slot.
  assign w_drop    = w_dump && w_fifo_full && !w_pop;
  assign out_valid = !w_fifo_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_dump) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (in_en) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_flag  <= 1'b0;
      drop_flag <= 1'b0;
    end else if (clr_flags) begin
      sat_flag  <= 1'b0;
      drop_flag <= 1'b0;
    end else begin
      if (w_dump && w_clamp) sat_flag  <= 1'b1;
      if (w_drop)            drop_flag <= 1'b1;
    end
  end

  iir_sample_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_dump),
    .pop   (out_ready),
    .din   (w_narrow),
    .dout  (outData),
    .empty (w_fifo_empty),
    .full  (w_fifo_full),
    .level (fifo_level)
  );

endmodule

`default_nettype wire

// File: tb/tb_iir_out_decimator.sv
// ---------------------------------------------------------------------------
// tb_iir_out_decimator : directed vector bench for iir_out_decimator.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_iir_out_decimator;

  import iir_pkg::*;

  logic               clk;
  logic               reset;
  sample_t            inData;
  logic               in_en;
  logic signed [15:0] outData;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         fifo_level;
  logic               sat_flag;
  logic               drop_flag;
  logic               clr_flags;

  int n_vec = 0;
  int n_bad = 0;

  iir_out_decimator dut (
    .clk        (clk),
    .reset      (reset),
    .inData     (inData),
    .in_en      (in_en),
    .outData    (outData),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .sat_flag   (sat_flag),
    .drop_flag  (drop_flag),
    .clr_flags  (clr_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [31:0] d0, d1, d2, d3;
    logic signed [15:0] exp_out;
    logic               exp_sat;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic signed [31:0] d);
    inData = d;
    in_en  = 1'b1;
    tick();
    in_en  = 1'b0;
  endtask

  task automatic block(input logic signed [31:0] a, b, c, d);
    sample(a); sample(b); sample(c); sample(d);
  endtask

  logic signed [15:0] exp_q [$];

  initial begin
    vecs[0]  = '{256, 256, 256, 256, 16'sd256, 1'b0};
    vecs[1]  = '{100, 101, 102, 103, 16'sd101, 1'b0};
    vecs[2]  = '{-1, -1, -1, -2, -16'sd2, 1'b0};
    vecs[3]  = '{10000000, 10000000, 10000000, 10000000, 16'sd32767, 1'b1};
    vecs[4]  = '{-10000000, -10000000, -10000000, -10000000, -16'sd32768, 1'b1};
    vecs[5]  = '{32767, 32767, 32767, 32767, 16'sd32767, 1'b0};
    vecs[6]  = '{-32768, -32768, -32768, -32768, -16'sd32768, 1'b0};
    vecs[7]  = '{32768, 32768, 32768, 32768, 16'sd32767, 1'b1};
    vecs[8]  = '{-32769, -32769, -32769, -32769, -16'sd32768, 1'b1};
    vecs[9]  = '{32'sh7fffffff, 32'sh7fffffff, 32'sh7fffffff, 32'sh7fffffff, 16'sd32767, 1'b1};
    vecs[10] = '{32'sh80000000, 32'sh80000000, 32'sh80000000, 32'sh80000000, -16'sd32768, 1'b1};
    vecs[11] = '{3, 0, 0, 0, 16'sd0, 1'b0};
    vecs[12] = '{-3, 0, 0, 0, -16'sd1, 1'b0};

    reset = 1'b0; inData = '0; in_en = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset outData", outData, 0);
    check("reset out_valid", out_valid, 0);
    check("reset level", fifo_level, 0);
    check("reset sat", sat_flag, 0);
    check("reset drop", drop_flag, 0);
    @(negedge clk) reset = 1'b1;
    tick();

    // Table: one block, read back, then pop and clear flags together.
    for (int i = 0; i < 13; i++) begin
      block(vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3);
      check($sformatf("vec%0d outData", i), outData, vecs[i].exp_out);
      check($sformatf("vec%0d valid", i), out_valid, 1);
      check($sformatf("vec%0d level", i), fifo_level, 1);
      check($sformatf("vec%0d sat", i), sat_flag, vecs[i].exp_sat);
      out_ready = 1'b1; clr_flags = 1'b1;
      tick();
      out_ready = 1'b0; clr_flags = 1'b0;
      check($sformatf("vec%0d popped valid", i), out_valid, 0);
      check($sformatf("vec%0d popped outData", i), outData, 0);
      check($sformatf("vec%0d cleared sat", i), sat_flag, 0);
    end

    // Idle cycles between samples must not advance the block.
    sample(100); tick(); tick();
    sample(101); tick();
    sample(102); tick(); tick(); tick();
    check("gap level before 4th", fifo_level, 0);
    check("gap valid before 4th", out_valid, 0);
    sample(103);
    check("gap outData", outData, 101);
    check("gap level", fifo_level, 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("gap drained", fifo_level, 0);

    // out_ready while empty is ignored; push lands.
    out_ready = 1'b1;
    sample(7); sample(7); sample(7);
    check("empty pop ignored level", fifo_level, 0);
    out_ready = 1'b0;
    sample(7);
    check("after empty pop outData", outData, 7);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Fill to 8 then overflow by one.
    for (int k = 0; k < 9; k++) begin
      block(1000 + k, 1000 + k, 1000 + k, 1000 + k);
      if (k < 8) exp_q.push_back(16'(1000 + k));
    end
    check("full level", fifo_level, 8);
    check("full drop", drop_flag, 1);
    check("full head", outData, 1000);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    check("drop cleared", drop_flag, 0);
    check("drop clear keeps level", fifo_level, 8);

    // Full + push + pop on one edge.
    sample(2000); sample(2000); sample(2000);
    out_ready = 1'b1;
    sample(2000);
    out_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(16'sd2000);
    check("push+pop level", fifo_level, 8);
    check("push+pop drop", drop_flag, 0);
    check("push+pop head", outData, 1001);

    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check($sformatf("drain%0d", j), outData, exp_q[j]);
      tick();
    end
    out_ready = 1'b0;
    check("drained valid", out_valid, 0);
    check("drained level", fifo_level, 0);

    // Reset mid-block with three entries queued.
    for (int k = 0; k < 3; k++) block(10000000, 10000000, 10000000, 10000000);
    sample(500); sample(500);
    check("pre-reset level", fifo_level, 3);
    check("pre-reset sat", sat_flag, 1);
    #2 reset = 1'b0;
    #1;
    check("async reset outData", outData, 0);
    check("async reset valid", out_valid, 0);
    check("async reset level", fifo_level, 0);
    check("async reset sat", sat_flag, 0);
    check("async reset drop", drop_flag, 0);
    @(negedge clk) reset = 1'b1;
    tick();
    block(128, 128, 128, 128);
    check("post-reset outData", outData, 128);
    check("post-reset level", fifo_level, 1);
    check("post-reset sat", sat_flag, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
